bcd_to_bin_seq: RTL
===================

Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is ≥8.
- Inverse path of the binary-to-BCD display chain; turns decimal digits entered on switches/keypad into binary operands for the adder datapath.
- start/busy/done handshake; one conversion in flight at a time.

Parameters:
- DIGITS, 2, number of packed BCD digits in bcd_in.
- BIN_W, 7, width of bin_out. Must satisfy 2^BIN_W > 10^DIGITS − 1 (2→7, 3→10, 4→14). Bench checks this legal pairing only.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]; sampled on the start edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when a result or error is presented.
- bin_out  output  BIN_W  binary result; holds until the next done.
- err  output  1  set with done if any input digit >9; holds until the next done.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, err, bin_out, internal BCD shift register, binary shift register and counter all 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, all digits ≤9:
  - Load bcd_in into bcd_r, clear bin_r, cnt=BIN_W.
  - Go to SHIFT.
- IDLE, start=1, any digit >9:
  - Go to DONE with an error flag set. No shifting.
- SHIFT, each cycle:
  - {bcd_r,bin_r} shifted right 1 (zero into MSB; bcd_r LSB enters bin_r MSB).
  - Then each 4-bit digit of the shifted bcd_r that is ≥8 has 3 subtracted (same cycle, combinational on the shifted value).
  - cnt decrements. When cnt==1 at the start of the cycle, the next state is DONE.
- busy=1 exactly in SHIFT, i.e. for BIN_W cycles.
- DONE (one cycle):
  - done=1.
  - Normal path: bin_out←bin_r, err←0.
  - Error path: bin_out←0, err←1.
  - Next state is IDLE.
- Latency: done is high in the cycle after the BIN_W-th SHIFT cycle, i.e. BIN_W+1 clock edges after the start edge. Error path: done in the cycle after the start edge.
- start while in SHIFT or DONE: ignored, not queued. bcd_in changes after the start edge: no effect.
- start held high continuously: a new conversion begins on every IDLE cycle. Back-to-back period is BIN_W+2 cycles.
- Residual bcd_r after the final shift is 0 for legal inputs, so the final correction step is harmless.
- bin_out and err change only on a done cycle or on reset.
- Reset mid-conversion: immediate return to IDLE with all outputs 0. No done is produced for the aborted request.

Test Plan:
- DIGITS=2/BIN_W=7, bcd_in=0x42, start 1 cycle -> busy high 7 cycles; done pulse 8 edges after start; bin_out=42 (0x2A); err=0.
- bcd_in=0x99 -> bin_out=99 (0x63). bcd_in=0x00 -> bin_out=0. bcd_in=0x10 -> bin_out=10. done pulses exactly 1 cycle each.
- bcd_in=0x3A -> done one cycle after the start edge; err=1; bin_out=0. Next legal request 0x07 -> bin_out=7, err=0.
- start=0x25, then start pulsed again with 0x88 during busy -> single done with bin_out=25. Then start held high with 0x13 -> done every 9 cycles, bin_out=13.
- rst_n low for 1 cycle at SHIFT cycle 3 of a 0x57 conversion -> outputs 0 immediately, no done. New start 0x57 -> bin_out=57.
- DIGITS=3/BIN_W=10, bcd_in=0x999 -> done 11 edges after start; bin_out=999 (0x3E7). Sweep all 1000 legal values against a reference model.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One bit of the BCD word moves into the binary register per SHIFT cycle.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // After a right shift a digit >= 8 holds a borrowed half-ten; subtracting 3 restores BCD.
    function automatic logic [BCD_W-1:0] dabble_fix(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (has_bad_digit(bcd_in)) begin
                        bin_out_d = '0;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = CNT_W'(BIN_W);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = dabble_fix(bcd_q >> 1);
                bin_d = {bcd_q[0], bin_q[BIN_W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                // Result registers load on entry to DONE so they are valid while done is high.
                if (cnt_q == CNT_W'(1)) begin
                    bin_out_d = bin_d;
                    err_d     = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule
